// File: rtl/data_bus_bridge.sv
// Data-memory responder for the single-cycle CPU: DRAM pass-through plus a
// memory-mapped peripheral block (7-seg, LED, switches, buttons, timer).
module data_bus_bridge #(
    parameter int DRAM_AW  = 16,
    parameter int PRESCALE = 50000
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [31:0]        data_addr,
    input  logic               data_wen,
    input  logic [31:0]        data_wdata,
    output logic [31:0]        data_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_wen,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         btn,
    output logic [23:0]        led,
    output logic [31:0]        seg_data
);

    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

    // Word offsets (byte offset >> 2) inside the peripheral page.
    localparam logic [9:0] OFF_SEG    = 10'h000;
    localparam logic [9:0] OFF_TCOUNT = 10'h008;
    localparam logic [9:0] OFF_TCTRL  = 10'h009;
    localparam logic [9:0] OFF_TCMP   = 10'h00A;
    localparam logic [9:0] OFF_TSTAT  = 10'h00B;
    localparam logic [9:0] OFF_LED    = 10'h018;
    localparam logic [9:0] OFF_SW     = 10'h01C;
    localparam logic [9:0] OFF_BTN    = 10'h01E;

    // Access protocol: no handshake. Every cycle is a read of data_addr that
    // completes combinationally; data_wen=1 also commits a write on the next
    // rising edge of cpu_clk. The responder never stalls.
    logic        periph_sel;
    logic [9:0]  off;
    logic        wr_periph;
    logic        wr_seg, wr_tcount, wr_tctrl, wr_tcmp, wr_tstat, wr_led;

    logic [23:0]   sw_meta, sw_sync;
    logic [4:0]    btn_meta, btn_sync;
    logic [31:0]   tcount, tcmp, tcount_inc;
    logic          timer_en, match;
    logic [PW-1:0] presc;
    logic          tick;
    logic          unused_addr_lsb;

    assign periph_sel = (data_addr[31:12] == 20'hFFFFF);
    assign off        = data_addr[11:2];
    assign wr_periph  = periph_sel && data_wen;
    assign wr_seg     = wr_periph && (off == OFF_SEG);
    assign wr_tcount  = wr_periph && (off == OFF_TCOUNT);
    assign wr_tctrl   = wr_periph && (off == OFF_TCTRL);
    assign wr_tcmp    = wr_periph && (off == OFF_TCMP);
    assign wr_tstat   = wr_periph && (off == OFF_TSTAT);
    assign wr_led     = wr_periph && (off == OFF_LED);

    assign dram_addr       = data_addr[DRAM_AW+1:2];
    assign dram_wdata      = data_wdata;
    assign dram_wen        = cpu_rst && !periph_sel && data_wen;
    assign unused_addr_lsb = ^data_addr[1:0];

    assign tick       = timer_en && (presc == PRESC_LAST);
    assign tcount_inc = tcount + 32'd1;

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
            led      <= '0;
            seg_data <= '0;
            tcount   <= '0;
            tcmp     <= '0;
            timer_en <= 1'b0;
            match    <= 1'b0;
            presc    <= '0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_sync <= btn_meta;

            if (wr_seg)   seg_data <= data_wdata;
            if (wr_led)   led      <= data_wdata[23:0];
            if (wr_tctrl) timer_en <= data_wdata[0];
            if (wr_tcmp)  tcmp     <= data_wdata;

            if (!timer_en || (presc == PRESC_LAST)) presc <= '0;
            else                                    presc <= presc + PW'(1);

            // A CPU write to TCOUNT overrides a coincident tick entirely.
            if (wr_tcount)  tcount <= data_wdata;
            else if (tick)  tcount <= tcount_inc;

            // Setting MATCH has priority over a write-1-to-clear.
            if (tick && !wr_tcount && (tcount_inc == tcmp)) match <= 1'b1;
            else if (wr_tstat && data_wdata[0])              match <= 1'b0;
        end
    end

    always_comb begin
        data_rdata = dram_rdata;
        if (periph_sel) begin
            case (off)
                OFF_SEG:    data_rdata = seg_data;
                OFF_TCOUNT: data_rdata = tcount;
                OFF_TCTRL:  data_rdata = {31'b0, timer_en};
                OFF_TCMP:   data_rdata = tcmp;
                OFF_TSTAT:  data_rdata = {31'b0, match};
                OFF_LED:    data_rdata = {8'b0, led};
                OFF_SW:     data_rdata = {8'b0, sw_sync};
                OFF_BTN:    data_rdata = {27'b0, btn_sync};
                default:    data_rdata = 32'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Scoreboard bench for data_bus_bridge: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_data_bus_bridge;

    localparam int PRESCALE = 4;
    localparam int DRAM_AW  = 16;

    localparam logic [31:0] A_SEG    = 32'hFFFF_F000;
    localparam logic [31:0] A_TCOUNT = 32'hFFFF_F020;
    localparam logic [31:0] A_TCTRL  = 32'hFFFF_F024;
    localparam logic [31:0] A_TCMP   = 32'hFFFF_F028;
    localparam logic [31:0] A_TSTAT  = 32'hFFFF_F02C;
    localparam logic [31:0] A_LED    = 32'hFFFF_F060;
    localparam logic [31:0] A_SW     = 32'hFFFF_F070;
    localparam logic [31:0] A_BTN    = 32'hFFFF_F078;

    localparam int S_RDATA = 0, S_LED = 1, S_SEG = 2, S_DADDR = 3, S_DWEN = 4, S_DWDATA = 5;

    logic               cpu_clk = 1'b0;
    logic               cpu_rst = 1'b0;
    logic [31:0]        data_addr = '0;
    logic               data_wen = 1'b0;
    logic [31:0]        data_wdata = '0;
    logic [31:0]        data_rdata;
    logic [DRAM_AW-1:0] dram_addr;
    logic               dram_wen;
    logic [31:0]        dram_wdata;
    logic [31:0]        dram_rdata;
    logic [23:0]        sw = '0;
    logic [4:0]         btn = '0;
    logic [23:0]        led;
    logic [31:0]        seg_data;

    data_bus_bridge #(.DRAM_AW(DRAM_AW), .PRESCALE(PRESCALE)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .data_addr(data_addr), .data_wen(data_wen), .data_wdata(data_wdata),
        .data_rdata(data_rdata),
        .dram_addr(dram_addr), .dram_wen(dram_wen), .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata),
        .sw(sw), .btn(btn), .led(led), .seg_data(seg_data)
    );

    // ---------------- clock / reset ----------------
    always #5 cpu_clk = ~cpu_clk;

    // Bench-side DRAM: read data is a fixed function of the address.
    function automatic logic [31:0] dram_pattern(logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction
    assign dram_rdata = dram_pattern(data_addr);

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          sel_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    int          pend = 0;
    int          obs_n = 0;

    logic [31:0] mon_exp, mon_act;
    int          mon_sel;
    string       mon_name;

    always @(negedge cpu_clk) begin
        for (int i = 0; i < obs_n; i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
                break;
            end
            mon_exp  = exp_q.pop_front();
            mon_sel  = sel_q.pop_front();
            mon_name = name_q.pop_front();
            case (mon_sel)
                S_RDATA: mon_act = data_rdata;
                S_LED:   mon_act = {8'h0, led};
                S_SEG:   mon_act = seg_data;
                S_DADDR: mon_act = 32'(dram_addr);
                S_DWEN:  mon_act = {31'h0, dram_wen};
                default: mon_act = dram_wdata;
            endcase
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", mon_name, mon_act, mon_exp);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] m_seg, m_tcount, m_tcmp;
    logic [23:0] m_led;
    logic        m_en, m_match;
    int          m_en_cycles;
    logic [23:0] sw_hist[$];
    logic [4:0]  btn_hist[$];

    task automatic model_reset();
        m_seg = '0; m_tcount = '0; m_tcmp = '0; m_led = '0;
        m_en = 1'b0; m_match = 1'b0; m_en_cycles = 0;
        sw_hist.delete();  sw_hist.push_back('0);  sw_hist.push_back('0);
        btn_hist.delete(); btn_hist.push_back('0); btn_hist.push_back('0);
    endtask

    function automatic logic [31:0] model_read(logic [31:0] a);
        if (a[31:12] != 20'hFFFFF) return dram_pattern(a);
        case (a[11:0] & 12'hFFC)
            12'h000: return m_seg;
            12'h020: return m_tcount;
            12'h024: return {31'h0, m_en};
            12'h028: return m_tcmp;
            12'h02C: return {31'h0, m_match};
            12'h060: return {8'h0, m_led};
            12'h070: return {8'h0, sw_hist[0]};
            12'h078: return {27'h0, btn_hist[0]};
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        logic        periph, tick, old_en, tc_wr, clr;
        logic [11:0] off;
        logic [31:0] old_cmp, inc;
        if (!cpu_rst) begin
            model_reset();
            return;
        end
        periph  = (data_addr[31:12] == 20'hFFFFF);
        off     = data_addr[11:0] & 12'hFFC;
        tick    = m_en && ((m_en_cycles % PRESCALE) == PRESCALE - 1);
        old_en  = m_en;
        old_cmp = m_tcmp;
        inc     = m_tcount + 32'd1;
        tc_wr   = 1'b0;
        clr     = 1'b0;
        if (periph && data_wen) begin
            case (off)
                12'h000: m_seg = data_wdata;
                12'h020: begin m_tcount = data_wdata; tc_wr = 1'b1; end
                12'h024: m_en = data_wdata[0];
                12'h028: m_tcmp = data_wdata;
                12'h02C: clr = data_wdata[0];
                12'h060: m_led = data_wdata[23:0];
                default: ;
            endcase
        end
        if (clr) m_match = 1'b0;
        if (tick && !tc_wr) begin
            m_tcount = inc;
            if (inc == old_cmp) m_match = 1'b1;
        end
        m_en_cycles = old_en ? m_en_cycles + 1 : 0;
        sw_hist.push_back(sw);   void'(sw_hist.pop_front());
        btn_hist.push_back(btn); void'(btn_hist.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic expect_obs(int sel, logic [31:0] v, string nm);
        exp_q.push_back(v);
        sel_q.push_back(sel);
        name_q.push_back(nm);
        pend++;
    endtask

    task automatic cycle();
        obs_n = pend;
        pend  = 0;
        model_step();
        @(posedge cpu_clk);
        #1;
        obs_n = 0;
    endtask

    task automatic rd(logic [31:0] a, string nm);
        data_addr = a;
        data_wen  = 1'b0;
        expect_obs(S_RDATA, model_read(a), nm);
        cycle();
    endtask

    task automatic rd_k(logic [31:0] a, logic [31:0] v, string nm);
        data_addr = a;
        data_wen  = 1'b0;
        expect_obs(S_RDATA, v, nm);
        cycle();
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] v);
        data_addr  = a;
        data_wen   = 1'b1;
        data_wdata = v;
        cycle();
        data_wen = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, v;
        int          r;

        model_reset();
        cpu_rst   = 1'b0;
        data_addr = 32'h0000_0104;
        data_wen  = 1'b1;
        repeat (2) @(posedge cpu_clk);
        #1;
        expect_obs(S_DWEN, 32'h0, "rst_dram_wen");
        expect_obs(S_LED, 32'h0, "rst_led");
        expect_obs(S_SEG, 32'h0, "rst_seg");
        cycle();
        rd_k(A_TCOUNT, 32'h0, "rst_tcount");
        cpu_rst = 1'b1;

        // DRAM pass-through and peripheral write isolation
        data_addr  = 32'h0000_0104;
        data_wen   = 1'b1;
        data_wdata = 32'hDEAD_BEEF;
        expect_obs(S_DWEN, 32'h1, "dram_wen");
        expect_obs(S_DADDR, 32'h41, "dram_addr");
        expect_obs(S_DWDATA, 32'hDEAD_BEEF, "dram_wdata");
        expect_obs(S_RDATA, dram_pattern(32'h0000_0104), "dram_rdata");
        cycle();
        data_addr  = A_LED;
        data_wdata = 32'hFFFF_FFFF;
        expect_obs(S_DWEN, 32'h0, "periph_dram_wen");
        cycle();
        data_wen = 1'b0;
        expect_obs(S_LED, 32'h00FF_FFFF, "led_port");
        rd_k(A_LED, 32'h00FF_FFFF, "led_read");
        wr(A_SEG, 32'h1234_5678);
        expect_obs(S_SEG, 32'h1234_5678, "seg_port");
        rd_k(A_SEG, 32'h1234_5678, "seg_read");
        rd_k(32'hFFFF_F003, 32'h1234_5678, "seg_read_lsb_ignored");
        rd_k(32'hFFFF_F100, 32'h0, "unmapped_read");
        wr(32'hFFFF_F100, 32'hFFFF_FFFF);
        wr(A_SW, 32'hFFFF_FFFF);
        rd_k(32'hFFFF_F100, 32'h0, "unmapped_after_write");

        // Synchronizer latency: sw changes just after an edge
        sw = 24'hA5A5A5;
        rd_k(A_SW, 32'h0, "sw_sync_edge1");
        rd_k(A_SW, 32'h0, "sw_sync_edge2");
        rd_k(A_SW, 32'h00A5_A5A5, "sw_sync_visible");

        // Timer: PRESCALE=4, TCMP=3; k counts cycles after the enabling edge
        wr(A_TCMP, 32'd3);
        wr(A_TCTRL, 32'h1);
        for (int k = 0; k < 12; k++) rd_k(A_TCOUNT, 32'(k / 4), "tcount_ramp");
        rd_k(A_TCOUNT, 32'd3, "tcount_12");
        rd_k(A_TSTAT, 32'd1, "match_set");
        wr(A_TSTAT, 32'h1);
        rd_k(A_TSTAT, 32'd0, "match_cleared");
        wr(A_TCOUNT, 32'hFFFF_FFFF);
        for (int k = 17; k < 20; k++) rd_k(A_TCOUNT, 32'hFFFF_FFFF, "tcount_max");
        rd_k(A_TCOUNT, 32'h0, "tcount_wrap");
        rd_k(A_TCTRL, 32'h1, "tctrl_read");
        rd_k(A_TCOUNT, 32'h0, "tcount_after_wrap");
        wr(A_TCOUNT, 32'h50);
        rd_k(A_TCOUNT, 32'h50, "tcount_write_wins");
        wr(A_TCMP, 32'h51);
        rd_k(A_TCOUNT, 32'h50, "tcount_hold");
        wr(A_TSTAT, 32'h1);
        rd_k(A_TSTAT, 32'h1, "match_set_wins");
        wr(A_TSTAT, 32'h1);
        rd_k(A_TSTAT, 32'h0, "match_clear2");
        rd_k(A_TCOUNT, 32'h51, "tcount_51");
        wr(A_TCMP, 32'h52);
        rd_k(A_TSTAT, 32'h0, "tcmp_write_no_match");
        rd_k(A_TCOUNT, 32'h52, "tcount_52");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) sw  = 24'($urandom);
            if ($urandom_range(0, 7) == 0) btn = 5'($urandom);
            r = $urandom_range(0, 9);
            case (r)
                0: a = A_SEG;
                1: a = A_TCOUNT;
                2: a = A_TCTRL;
                3: a = A_TCMP;
                4: a = A_TSTAT;
                5: a = A_LED;
                6: a = A_SW;
                7: a = A_BTN;
                8: a = 32'hFFFF_F000 | 32'($urandom_range(12'h080, 12'hFFF));
                default: begin
                    a = $urandom;
                    if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
                end
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            v = $urandom;
            if (r == 3) v = m_tcount + 32'($urandom_range(0, 3));
            if (r == 2) v[0] = ($urandom_range(0, 3) != 0);
            if (r == 1 && $urandom_range(0, 3) != 0) v = m_tcount;
            data_addr  = a;
            data_wdata = v;
            data_wen   = (r == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
            expect_obs(S_RDATA, model_read(a), "rand_rdata");
            if (data_wen) expect_obs(S_DWEN, (a[31:12] == 20'hFFFFF) ? 32'h0 : 32'h1, "rand_dram_wen");
            if (n % 16 == 0) begin
                expect_obs(S_LED, {8'h0, m_led}, "rand_led");
                expect_obs(S_SEG, m_seg, "rand_seg");
            end
            cycle();
            data_wen = 1'b0;
        end

        // Asynchronous reset mid-count, asserted between edges
        wr(A_LED, 32'h00AB_CDEF);
        wr(A_TCTRL, 32'h1);
        for (int k = 0; k < 6; k++) rd(A_TCOUNT, "pre_reset_tcount");
        #2;
        cpu_rst = 1'b0;
        model_reset();
        data_addr = 32'h0000_0200;
        data_wen  = 1'b1;
        expect_obs(S_DWEN, 32'h0, "async_rst_dram_wen");
        expect_obs(S_LED, 32'h0, "async_rst_led");
        expect_obs(S_SEG, 32'h0, "async_rst_seg");
        cycle();
        data_wen = 1'b0;
        rd_k(A_TCOUNT, 32'h0, "async_rst_tcount");
        rd_k(A_LED, 32'h0, "async_rst_led_read");
        cpu_rst = 1'b1;
        for (int k = 0; k < 6; k++) rd_k(A_TCOUNT, 32'h0, "post_rst_tcount");
        rd_k(A_TCTRL, 32'h0, "post_rst_tctrl");

        @(posedge cpu_clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_bus_bridge.md
# data_bus_bridge

Responder for the CPU's data-memory port: accepts the single-cycle CPU's `data_addr`/`data_wen`/`data_wdata` requests and returns `data_rdata` in the same cycle. The address space is split between the external DRAM (pass-through) and a small memory-mapped peripheral block containing LED, 7-segment, switch, button and timer registers. It sits between `myCPU`'s DRAM interface and the board-level RAM and I/O.

## Interface
Parameters:
- `DRAM_AW`, 16: DRAM word-address width.
- `PRESCALE`, 50000: `cpu_clk` cycles per timer tick, ≥1.

Ports:
- `cpu_clk`  in  1  system clock; all state updates on its rising edge.
- `cpu_rst`  in  1  asynchronous, active-low reset.
- `data_addr`  in  32  CPU byte address.
- `data_wen`  in  1  CPU write strobe; one write per asserted cycle.
- `data_wdata`  in  32  CPU write data.
- `data_rdata`  out  32  read data, combinational from `data_addr`.
- `dram_addr`  out  DRAM_AW  word address, `data_addr[DRAM_AW+1:2]`.
- `dram_wen`  out  1  DRAM write enable.
- `dram_wdata`  out  32  equals `data_wdata`.
- `dram_rdata`  in  32  DRAM read data (asynchronous read).
- `sw`  in  24  board switches, asynchronous.
- `btn`  in  5  board buttons, asynchronous.
- `led`  out  24  LED register.
- `seg_data`  out  32  7-segment display value register.

## Operation
- Decode: peripheral region when `data_addr[31:12] == 20'hFFFFF`, else DRAM.
- DRAM region: `dram_wen = data_wen`. `data_rdata = dram_rdata`.
- Peripheral region: `dram_wen = 0`. Offset is `data_addr[11:0]`:
  - 0x000 SEG, RW, 32 bits.
  - 0x020 TCOUNT, RW: timer count.
  - 0x024 TCTRL, RW: bit0 EN, other bits read 0.
  - 0x028 TCMP, RW: compare value.
  - 0x02C TSTAT, RW1C: bit0 MATCH, sticky.
  - 0x060 LED, RW, bits [23:0]; upper bits read 0.
  - 0x070 SW, RO: synchronized `sw`, zero-extended.
  - 0x078 BTN, RO: synchronized `btn`, zero-extended.
- Unmapped peripheral offsets read 0. Writes to them, and to RO registers, are ignored.
- Synchronizers: two-flop chains on `sw` and `btn`.
- Prescaler, range 0..PRESCALE-1:
  - Increments each cycle while EN=1.
  - At PRESCALE-1 it wraps to 0 and issues a one-cycle tick.
  - Forced to 0 while EN=0.
- Tick: TCOUNT increments modulo 2^32 (0xFFFFFFFF → 0). If the incremented value equals TCMP, MATCH is set.
- Simultaneous events:
  - CPU write to TCOUNT in a tick cycle: written value wins, no increment. MATCH is not evaluated against the written value.
  - Write-1 to TSTAT in a cycle where MATCH is being set: MATCH ends at 1 (set wins).
  - Writing TCMP equal to the current TCOUNT does not set MATCH. Only a tick can set it.
- Address bits [1:0] are ignored everywhere. Only full-word accesses are supported.

## Timing
- Reads: zero latency. `data_rdata` is combinational, valid in the same cycle as `data_addr`.
- Writes: register and DRAM updates take effect on the rising edge where `data_wen=1`. The new value is readable in the next cycle.
- `sw`/`btn` changes appear in SW/BTN reads 2 edges after the input settles.
- Tick spacing with EN held at 1: exactly PRESCALE cycles. The first tick comes PRESCALE edges after the edge that sets EN.
- Reset (`cpu_rst=0`, asynchronous) clears `led`, `seg_data`, TCOUNT, TCTRL, TCMP, MATCH, prescaler and both synchronizer chains to 0.
  - During reset `dram_wen` is forced 0.
  - `data_rdata` still reflects the decode of the (cleared) registers or `dram_rdata`.
- Reset deasserted mid-count: the timer restarts from 0 with EN=0.

## Test plan
- DRAM pass-through: write 0xDEADBEEF to 0x0000_0104 → `dram_wen=1`, `dram_addr=0x41`, `dram_wdata=0xDEADBEEF`. A peripheral write to 0xFFFF_F060 → `dram_wen=0`.
- LED/SEG: write 0xFFFFFFFF to 0xFFFF_F060 → `led=0xFFFFFF`, and a readback gives 0x00FFFFFF. Write 0x12345678 to 0xFFFF_F000 → `seg_data=0x12345678`. A read of 0xFFFF_F100 returns 0.
- Synchronizer: `sw=0xA5A5A5` at edge N → a SW read returns 0 through edge N+1 and 0x00A5A5A5 from edge N+2.
- Timer with PRESCALE=4: TCMP=3, EN=1 → TCOUNT reaches 1, 2, 3 at 4, 8, 12 cycles after enable. MATCH=1 at the 12th edge. A write of 1 to TSTAT clears it.
- Collisions: TCOUNT=0xFFFFFFFF with a tick → 0. A TCOUNT write of 0x50 coincident with a tick → 0x50. A TSTAT clear coincident with a match → MATCH=1.
- Async reset: assert `cpu_rst=0` mid-count, between edges → all registers read 0 immediately, `led=0`, `dram_wen=0`. After release, EN=0 and TCOUNT stays 0.
